// File: rtl/foo_pkg.sv
// Shared types and helpers for the foo field narrowing logic.
// narrow_sat() is only referenced when FOO_SAT_EN is defined.
package foo_pkg;

   localparam int unsigned FOO_W = 8;

   typedef logic [FOO_W-1:0] foo_t;

   // Saturate to all ones when any discarded upper bit was set.
   function automatic foo_t narrow_sat(input foo_t lo, input logic hi_nz);
      return hi_nz ? {FOO_W{1'b1}} : lo;
   endfunction

endpackage

// File: rtl/foo_narrow.sv
// Combinational width narrowing of a wide word to FOO_W bits, plus upper-bit detect.
// Define FOO_SAT_EN to saturate instead of truncate when upper bits are non-zero.
module foo_narrow
   import foo_pkg::*;
#(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned FOO_W = foo_pkg::FOO_W
) (
   input  logic [IN_W-1:0]  in_data,
   output logic [FOO_W-1:0] narrow_o,
   output logic             hi_nz_o
);

   logic [FOO_W-1:0] lo;

   assign lo = in_data[FOO_W-1:0];

   if (FOO_W < IN_W) begin : g_hi
      assign hi_nz_o = |in_data[IN_W-1:FOO_W];
   end else begin : g_no_hi
      assign hi_nz_o = 1'b0;
   end

`ifdef FOO_SAT_EN
   if (FOO_W == foo_pkg::FOO_W) begin : g_sat_pkg
      assign narrow_o = narrow_sat(lo, hi_nz_o);
   end else begin : g_sat_gen
      assign narrow_o = hi_nz_o ? {FOO_W{1'b1}} : lo;
   end
`else
   assign narrow_o = lo;
`endif

endmodule

// File: rtl/foo_narrow_reg.sv
// Registered holder for the narrowed foo field with a sticky overflow flag.
// Saturating narrowing is selected by defining FOO_SAT_EN.
module foo_narrow_reg
   import foo_pkg::*;
#(
   parameter int unsigned    IN_W      = 32,
   parameter int unsigned    FOO_W     = foo_pkg::FOO_W,
   parameter logic [FOO_W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             clr_ovf,
   output logic [FOO_W-1:0] foo,
   output logic             foo_valid,
   output logic             ovf
);

   logic [FOO_W-1:0] foo_q, foo_d, narrow;
   logic             foo_valid_q, foo_valid_d;
   logic             ovf_q, ovf_d;
   logic             hi_nz;
   logic             accept;

   foo_narrow #(
      .IN_W  (IN_W),
      .FOO_W (FOO_W)
   ) u_narrow (
      .in_data  (in_data),
      .narrow_o (narrow),
      .hi_nz_o  (hi_nz)
   );

   // No back-pressure: ready whenever out of reset.
   assign in_ready = rst_n;
   assign accept   = in_valid & in_ready;

   always_comb begin
      foo_d       = foo_q;
      foo_valid_d = foo_valid_q;
      if (accept) begin
         foo_d       = narrow;
         foo_valid_d = 1'b1;
      end
      // Set takes priority over a same-cycle clear.
      ovf_d = (ovf_q & ~clr_ovf) | (accept & hi_nz);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         foo_q       <= RESET_VAL;
         foo_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         foo_q       <= foo_d;
         foo_valid_q <= foo_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign foo       = foo_q;
   assign foo_valid = foo_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_foo_narrow_reg.sv
// Directed self-checking bench for foo_narrow_reg (default parameters).
// Expected values follow FOO_SAT_EN when the bench is built with it defined.
module tb_foo_narrow_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        clr_ovf;
   logic [7:0]  foo;
   logic        foo_valid;
   logic        ovf;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef FOO_SAT_EN
   localparam logic [7:0] Exp105 = 8'hFF;
   localparam logic [7:0] Exp200 = 8'hFF;
   localparam logic [7:0] Exp1ff = 8'hFF;
   localparam logic [7:0] ExpF80 = 8'hFF;
`else
   localparam logic [7:0] Exp105 = 8'h05;
   localparam logic [7:0] Exp200 = 8'h00;
   localparam logic [7:0] Exp1ff = 8'hFF;
   localparam logic [7:0] ExpF80 = 8'h80;
`endif

   foo_narrow_reg u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .clr_ovf   (clr_ovf),
      .foo       (foo),
      .foo_valid (foo_valid),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_foo, input logic e_fv,
                            input logic e_ovf, input logic e_rdy);
      check({tag, ".foo"}, 32'(foo), 32'(e_foo));
      check({tag, ".foo_valid"}, 32'(foo_valid), 32'(e_fv));
      check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      clr_ovf  = 1'b0;
      @(negedge clk);
      tick();
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      rst_n = 1'b1;
      #1;
      check("ready_after_reset", 32'(in_ready), 32'd1);

      in_valid = 1'b1;
      in_data  = 32'd5;
      tick();
      check_all("load5", 8'h05, 1'b1, 1'b0, 1'b1);

      in_data = 32'h0000_0105;
      tick();
      check_all("load105", Exp105, 1'b1, 1'b1, 1'b1);

      in_valid = 1'b0;
      in_data  = 32'h0000_00AA;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_all("idle_hold", Exp105, 1'b1, 1'b1, 1'b1);
      end

      in_valid = 1'b1;
      in_data  = 32'h0000_0200;
      clr_ovf  = 1'b1;
      tick();
      check_all("set_beats_clr", Exp200, 1'b1, 1'b1, 1'b1);

      in_valid = 1'b0;
      tick();
      check_all("clr_alone", Exp200, 1'b1, 1'b0, 1'b1);

      clr_ovf  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0000_01FF;
      tick();
      check_all("load1ff", Exp1ff, 1'b1, 1'b1, 1'b1);

      rst_n   = 1'b0;
      in_data = 32'd7;
      #1;
      check("ready_low_in_reset", 32'(in_ready), 32'd0);
      tick();
      check_all("reset_over_accept", 8'h00, 1'b0, 1'b0, 1'b0);

      rst_n   = 1'b1;
      in_data = 32'hFFFF_FF80;
      tick();
      check_all("loadF80", ExpF80, 1'b1, 1'b1, 1'b1);

      in_data = 32'h0000_0012;
      tick();
      check_all("b2b_12", 8'h12, 1'b1, 1'b1, 1'b1);
      in_data = 32'h0000_0034;
      tick();
      check_all("b2b_34", 8'h34, 1'b1, 1'b1, 1'b1);

      in_valid = 1'b0;
      clr_ovf  = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      tick();
      check_all("hold_no_valid", 8'h34, 1'b1, 1'b0, 1'b1);

      clr_ovf  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0000_00C3;
      tick();
      check_all("in_range_no_ovf", 8'hC3, 1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
